// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and constants for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_MEM    = 3'd1,
    ST_WAIT_PERIPH = 3'd2,
    ST_WAIT_CORE   = 3'd3,
    ST_RUN         = 3'd4,
    ST_HOLD        = 3'd5
  } rst_state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;

  localparam logic [2:0] CAUSE_RESET = 3'b001;

  // Cause vector for an accepted request; both bits set when sw and wdt coincide.
  function automatic logic [2:0] req_cause(input logic wdt, input logic sw);
    logic [2:0] c;
    c            = '0;
    c[CAUSE_WDT] = wdt;
    c[CAUSE_SW]  = sw;
    return c;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - control/reset bundle between the sequencer and its environment
interface rst_seq_ctrl_if;

  logic       testmode_i;
  logic       sw_rst_req_i;
  logic       wdt_rst_req_i;
  logic       fetch_enable_i;
  logic       mem_rstn_o;
  logic       periph_rstn_o;
  logic       core_rstn_o;
  logic       fetch_enable_o;
  logic       seq_done_o;
  logic [2:0] rst_cause_o;

  modport master (
    output testmode_i, sw_rst_req_i, wdt_rst_req_i, fetch_enable_i,
    input  mem_rstn_o, periph_rstn_o, core_rstn_o, fetch_enable_o,
           seq_done_o, rst_cause_o
  );

  modport slave (
    input  testmode_i, sw_rst_req_i, wdt_rst_req_i, fetch_enable_i,
    output mem_rstn_o, periph_rstn_o, core_rstn_o, fetch_enable_o,
           seq_done_o, rst_cause_o
  );

endinterface

// File: rtl/rst_seq_ctrl_dly_cnt.sv
// rtl/rst_seq_ctrl_dly_cnt.sv - shared wait-state delay counter with terminal-count compare
module rst_dly_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Count while enabled; clear wins so each wait state starts from zero.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = en && (cnt == tc_val);

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staggered mem/periph/core reset release with sw/wdt re-sequencing
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int MEM_DLY    = 4,
  parameter int PERIPH_DLY = 8,
  parameter int CORE_DLY   = 16,
  parameter int HOLD_CYC   = 32,
  parameter int CNT_W      = 6
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  rst_seq_ctrl_if.slave bus
);

  localparam int DLY_MAX = (1 << CNT_W) - 1;

  if (CNT_W < 1 ||
      MEM_DLY < 1 || MEM_DLY > DLY_MAX ||
      PERIPH_DLY < 1 || PERIPH_DLY > DLY_MAX ||
      CORE_DLY < 1 || CORE_DLY > DLY_MAX ||
      HOLD_CYC < 1 || HOLD_CYC > DLY_MAX) begin : g_param_check
    $error("rst_seq_ctrl: delay parameter outside 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MEM_TC    = CNT_W'(MEM_DLY - 1);
  localparam logic [CNT_W-1:0] PERIPH_TC = CNT_W'(PERIPH_DLY - 1);
  localparam logic [CNT_W-1:0] CORE_TC   = CNT_W'(CORE_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYC - 1);

  rst_state_e       state, state_n;
  logic             mem_q, periph_q, core_q, fe_q, done_q;
  logic             mem_n, periph_n, core_n, fe_n, done_n;
  logic [2:0]       cause_q, cause_n;
  logic             req;
  logic             cnt_en, cnt_clr, tc;
  logic [CNT_W-1:0] tc_val;

  assign req = bus.sw_rst_req_i | bus.wdt_rst_req_i;

  rst_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk    (clk_i),
    .rstn   (rstn_i),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (tc_val),
    .tc     (tc)
  );

  // Next state and next output register values; every output holds unless a transition moves it.
  always_comb begin
    state_n  = state;
    mem_n    = mem_q;
    periph_n = periph_q;
    core_n   = core_q;
    done_n   = done_q;
    cause_n  = cause_q;
    fe_n     = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b1;
    tc_val   = '0;
    case (state)
      ST_RESET: begin
        state_n = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        tc_val  = MEM_TC;
        if (tc) begin
          mem_n   = 1'b1;
          state_n = ST_WAIT_PERIPH;
        end
      end
      ST_WAIT_PERIPH: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        tc_val  = PERIPH_TC;
        if (tc) begin
          periph_n = 1'b1;
          state_n  = ST_WAIT_CORE;
        end
      end
      ST_WAIT_CORE: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        tc_val  = CORE_TC;
        if (tc) begin
          core_n  = 1'b1;
          done_n  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        fe_n = bus.fetch_enable_i;
        if (req) begin
          // Memory stays out of reset so its contents survive a soft reset.
          core_n   = 1'b0;
          periph_n = 1'b0;
          fe_n     = 1'b0;
          done_n   = 1'b0;
          cause_n  = req_cause(bus.wdt_rst_req_i, bus.sw_rst_req_i);
          state_n  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        tc_val  = HOLD_TC;
        if (tc) begin
          state_n = ST_WAIT_PERIPH;
        end
      end
      default: begin
        state_n = ST_RESET;
      end
    endcase
  end

  // State and output registers; rstn_i returns everything to the power-on view.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= ST_RESET;
      mem_q    <= 1'b0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      fe_q     <= 1'b0;
      done_q   <= 1'b0;
      cause_q  <= CAUSE_RESET;
    end else begin
      state    <= state_n;
      mem_q    <= mem_n;
      periph_q <= periph_n;
      core_q   <= core_n;
      fe_q     <= fe_n;
      done_q   <= done_n;
      cause_q  <= cause_n;
    end
  end

  // DFT bypass: resets and fetch enable come straight from the pins while the FSM keeps running.
  assign bus.mem_rstn_o     = bus.testmode_i ? rstn_i : mem_q;
  assign bus.periph_rstn_o  = bus.testmode_i ? rstn_i : periph_q;
  assign bus.core_rstn_o    = bus.testmode_i ? rstn_i : core_q;
  assign bus.fetch_enable_o = bus.testmode_i ? bus.fetch_enable_i : fe_q;
  assign bus.seq_done_o     = done_q;
  assign bus.rst_cause_o    = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - scoreboard bench for the reset sequencer
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  rst_seq_ctrl_if bus();

  rst_seq_ctrl dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev = 8'bx;

  wire [7:0] obs = {bus.mem_rstn_o, bus.periph_rstn_o, bus.core_rstn_o,
                    bus.fetch_enable_o, bus.seq_done_o, bus.rst_cause_o};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] v(bit m, bit p, bit c, bit f, bit d, logic [2:0] cause);
    return {m, p, c, f, d, cause};
  endfunction

  task automatic expect_at(int c, logic [7:0] val);
    exp_t e;
    e.cyc = c;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, int got, int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Power-on style release: mem, periph, core at +4/+12/+28, fetch one edge later.
  task automatic por_expect(int e0);
    expect_at(e0 + 4,  v(1, 0, 0, 0, 0, 3'b001));
    expect_at(e0 + 12, v(1, 1, 0, 0, 0, 3'b001));
    expect_at(e0 + 28, v(1, 1, 1, 0, 1, 3'b001));
    expect_at(e0 + 29, v(1, 1, 1, 1, 1, 3'b001));
  endtask

  // Accepted request at edge s: hold 32, then periph +8, core +16, fetch +1.
  task automatic reseq_expect(int s, logic [2:0] cause);
    expect_at(s,      v(1, 0, 0, 0, 0, cause));
    expect_at(s + 40, v(1, 1, 0, 0, 0, cause));
    expect_at(s + 56, v(1, 1, 1, 0, 1, cause));
    expect_at(s + 57, v(1, 1, 1, 1, 1, cause));
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (obs !== prev) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change cyc=%0d got=%b want=no_change", cyc, obs);
          end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.val !== obs) begin
              miscompares++;
              $display("FAIL output_event cyc=%0d got=%b want cyc=%0d val=%b",
                       cyc, obs, e.cyc, e.val);
            end
          end
          prev = obs;
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
          vectors++;
          miscompares++;
          e = sb.pop_front();
          $display("FAIL missing_event cyc=%0d got=%b want cyc=%0d val=%b",
                   cyc, obs, e.cyc, e.val);
        end
      end
    end
  endtask

  initial begin
    int s;
    int e0;
    bus.testmode_i     = 1'b0;
    bus.sw_rst_req_i   = 1'b0;
    bus.wdt_rst_req_i  = 1'b0;
    bus.fetch_enable_i = 1'b1;
    rstn               = 1'b0;

    fork
      monitor();
    join_none

    expect_at(1, v(0, 0, 0, 0, 0, 3'b001));
    mon_en = 1'b1;

    // Power-on sequence
    step(5);
    e0 = cyc + 1;
    por_expect(e0);
    rstn = 1'b1;
    step(35);

    // Software reset in RUN
    s = cyc + 1;
    reseq_expect(s, 3'b010);
    bus.sw_rst_req_i = 1'b1;
    step(1);
    bus.sw_rst_req_i = 1'b0;
    step(70);

    // Simultaneous sw+wdt, then an ignored wdt pulse during WAIT_CORE
    s = cyc + 1;
    reseq_expect(s, 3'b110);
    bus.sw_rst_req_i  = 1'b1;
    bus.wdt_rst_req_i = 1'b1;
    step(1);
    bus.sw_rst_req_i  = 1'b0;
    bus.wdt_rst_req_i = 1'b0;
    step(44);
    bus.wdt_rst_req_i = 1'b1;
    step(1);
    bus.wdt_rst_req_i = 1'b0;
    step(30);

    // Software reset, then rstn_i asserted 10 edges into HOLD
    s = cyc + 1;
    expect_at(s, v(1, 0, 0, 0, 0, 3'b010));
    expect_at(s + 10, v(0, 0, 0, 0, 0, 3'b001));
    bus.sw_rst_req_i = 1'b1;
    step(1);
    bus.sw_rst_req_i = 1'b0;
    step(9);
    rstn = 1'b0;
    step(3);
    e0 = cyc + 1;
    por_expect(e0);
    rstn = 1'b1;
    step(40);

    // Watchdog-only request
    s = cyc + 1;
    reseq_expect(s, 3'b100);
    bus.wdt_rst_req_i = 1'b1;
    step(1);
    bus.wdt_rst_req_i = 1'b0;
    step(70);

    mon_en = 1'b0;
    check("scoreboard_drained", sb.size(), 0);

    // Test mode: resets and fetch enable follow the pins with no clock delay
    bus.testmode_i = 1'b1;
    rstn = 1'b0;
    step(2);
    #1;
    check("tm_rstn_low", {bus.mem_rstn_o, bus.periph_rstn_o, bus.core_rstn_o}, 0);
    bus.fetch_enable_i = 1'b0;
    #1;
    check("tm_fetch_low", bus.fetch_enable_o, 0);
    bus.fetch_enable_i = 1'b1;
    #1;
    check("tm_fetch_high", bus.fetch_enable_o, 1);
    step(1);
    rstn = 1'b1;
    #1;
    check("tm_rstn_rise_in_reset", {bus.mem_rstn_o, bus.periph_rstn_o, bus.core_rstn_o}, 7);
    step(12);
    rstn = 1'b0;
    #1;
    check("tm_rstn_fall_mid_seq", {bus.mem_rstn_o, bus.periph_rstn_o, bus.core_rstn_o}, 0);
    step(1);
    rstn = 1'b1;
    #1;
    check("tm_rstn_rise_again", {bus.mem_rstn_o, bus.periph_rstn_o, bus.core_rstn_o}, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
